// File: rtl/mci_cif_router_pkg.sv
// Shared types for the MCI CIF router: FSM states, the captured request record
// and the base/mask window match used by the address decoder.
package mci_cif_router_pkg;

  // The request record is sized for the widest supported fabric; narrower
  // instances zero-extend into it and slice back out.
  localparam int AW_MAX = 64;
  localparam int DW_MAX = 128;
  localparam int WS_MAX = DW_MAX / 8;
  localparam int UW_MAX = 64;
  localparam int IW_MAX = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [AW_MAX-1:0] addr;
    logic              write;
    logic [UW_MAX-1:0] user;
    logic [IW_MAX-1:0] id;
    logic [DW_MAX-1:0] wdata;
    logic [WS_MAX-1:0] wstrb;
  } cif_req_t;

  function automatic logic window_hit(input logic [AW_MAX-1:0] addr,
                                      input logic [AW_MAX-1:0] base,
                                      input logic [AW_MAX-1:0] mask);
    return (addr & ~mask) == base;
  endfunction

endpackage

// File: rtl/mci_cif_router_if.sv
// Upstream CIF request/response bus between the AXI subordinate (master side)
// and the router (slave side).
interface mci_cif_router_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int UW = 32,
  parameter int IW = 8
) ();

  logic            req_dv;
  logic [AW-1:0]   req_addr;
  logic            req_write;
  logic [UW-1:0]   req_user;
  logic [IW-1:0]   req_id;
  logic [DW-1:0]   req_wdata;
  logic [DW/8-1:0] req_wstrb;
  logic            resp_hold;
  logic            resp_error;
  logic [DW-1:0]   resp_rdata;

  modport master (
    output req_dv, req_addr, req_write, req_user, req_id, req_wdata, req_wstrb,
    input  resp_hold, resp_error, resp_rdata
  );

  modport slave (
    input  req_dv, req_addr, req_write, req_user, req_id, req_wdata, req_wstrb,
    output resp_hold, resp_error, resp_rdata
  );

endinterface

// File: rtl/mci_cif_addr_decode.sv
// Combinational base/mask window decoder; overlapping windows resolve to the
// lowest target index.
module mci_cif_addr_decode
  import mci_cif_router_pkg::*;
#(
  parameter int                    AW       = 32,
  parameter int                    NUM_TGT  = 4,
  parameter int                    SEL_W    = 2,
  parameter logic [NUM_TGT*AW-1:0] TGT_BASE = '0,
  parameter logic [NUM_TGT*AW-1:0] TGT_MASK = '0
) (
  input  logic [AW-1:0]      addr,
  output logic [NUM_TGT-1:0] hit,
  output logic [SEL_W-1:0]   sel,
  output logic               any_hit
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TGT; gi++) begin : g_win
      assign hit[gi] = window_hit(AW_MAX'(addr),
                                  AW_MAX'(TGT_BASE[gi*AW +: AW]),
                                  AW_MAX'(TGT_MASK[gi*AW +: AW]));
    end
  endgenerate

  // Scan downwards so the last assignment wins: the lowest hitting index.
  always_comb begin
    sel = '0;
    for (int i = NUM_TGT - 1; i >= 0; i--) begin
      if (hit[i]) sel = SEL_W'(i);
    end
  end

  assign any_hit = |hit;

endmodule

// File: rtl/mci_cif_router.sv
// N-target CIF router: window decode, one-hot target issue with watchdog,
// privilege classification from the AXI user and a registered response.
module mci_cif_router
  import mci_cif_router_pkg::*;
#(
  parameter int                    AW             = 32,
  parameter int                    DW             = 32,
  parameter int                    UW             = 32,
  parameter int                    IW             = 8,
  parameter int                    NUM_TGT        = 4,
  parameter logic [NUM_TGT*AW-1:0] TGT_BASE       = {32'h0003_0000, 32'h0002_0000,
                                                     32'h0001_0000, 32'h0000_0000},
  parameter logic [NUM_TGT*AW-1:0] TGT_MASK       = {32'h0000_FFFF, 32'h0000_FFFF,
                                                     32'h0000_FFFF, 32'h0000_FFFF},
  parameter int                    NUM_PRIV       = 3,
  parameter int                    TIMEOUT_CYCLES = 256,
  parameter int                    CNT_W          = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  mci_cif_router_if.slave        bus,
  output logic [NUM_TGT-1:0]     tgt_dv,
  output logic [AW-1:0]          tgt_addr,
  output logic                   tgt_write,
  output logic [UW-1:0]          tgt_user,
  output logic [IW-1:0]          tgt_id,
  output logic [DW-1:0]          tgt_wdata,
  output logic [DW/8-1:0]        tgt_wstrb,
  input  logic [NUM_TGT-1:0]     tgt_hold,
  input  logic [NUM_TGT-1:0]     tgt_error,
  input  logic [NUM_TGT*DW-1:0]  tgt_rdata,
  input  logic [NUM_PRIV*UW-1:0] strap_priv_user,
  output logic [NUM_PRIV-1:0]    priv_req,
  output logic                   soc_req,
  output logic [CNT_W-1:0]       decode_err_cnt,
  output logic [CNT_W-1:0]       timeout_cnt,
  output logic                   timeout_pulse
);

  localparam int              SEL_W     = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
  localparam int              WAIT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit              WDOG_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  state_t              state_reg;
  cif_req_t            req_reg;
  cif_req_t            req_in;
  logic [SEL_W-1:0]    sel_reg;
  logic [WAIT_W-1:0]   wait_cnt_reg;
  logic [NUM_TGT-1:0]  tgt_dv_reg;
  logic                resp_hold_reg;
  logic                resp_error_reg;
  logic [DW-1:0]       resp_rdata_reg;
  logic [NUM_PRIV-1:0] priv_req_reg;
  logic                soc_req_reg;
  logic [CNT_W-1:0]    decode_err_cnt_reg;
  logic [CNT_W-1:0]    timeout_cnt_reg;
  logic                timeout_pulse_reg;

  logic [NUM_TGT-1:0]  dec_hit;
  logic [SEL_W-1:0]    dec_sel;
  logic                dec_any_hit;
  logic [NUM_PRIV-1:0] priv_match;
  logic                unused_bits;

  mci_cif_addr_decode #(
    .AW       (AW),
    .NUM_TGT  (NUM_TGT),
    .SEL_W    (SEL_W),
    .TGT_BASE (TGT_BASE),
    .TGT_MASK (TGT_MASK)
  ) u_decode (
    .addr    (bus.req_addr),
    .hit     (dec_hit),
    .sel     (dec_sel),
    .any_hit (dec_any_hit)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PRIV; gi++) begin : g_priv
      assign priv_match[gi] = (bus.req_user == strap_priv_user[gi*UW +: UW]);
    end
  endgenerate

  always_comb begin
    req_in       = '0;
    req_in.addr  = AW_MAX'(bus.req_addr);
    req_in.write = bus.req_write;
    req_in.user  = UW_MAX'(bus.req_user);
    req_in.id    = IW_MAX'(bus.req_id);
    req_in.wdata = DW_MAX'(bus.req_wdata);
    req_in.wstrb = WS_MAX'(bus.req_wstrb);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= IDLE;
      req_reg            <= '0;
      sel_reg            <= '0;
      wait_cnt_reg       <= '0;
      tgt_dv_reg         <= '0;
      resp_hold_reg      <= 1'b1;
      resp_error_reg     <= 1'b0;
      resp_rdata_reg     <= '0;
      priv_req_reg       <= '0;
      soc_req_reg        <= 1'b0;
      decode_err_cnt_reg <= '0;
      timeout_cnt_reg    <= '0;
      timeout_pulse_reg  <= 1'b0;
    end else begin
      timeout_pulse_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.req_dv) begin
            req_reg      <= req_in;
            sel_reg      <= dec_sel;
            wait_cnt_reg <= '0;
            priv_req_reg <= priv_match;
            soc_req_reg  <= ~|priv_match;
            if (dec_any_hit) begin
              state_reg  <= ISSUE;
              tgt_dv_reg <= NUM_TGT'(1) << dec_sel;
            end else begin
              state_reg      <= RESP;
              resp_hold_reg  <= 1'b0;
              resp_error_reg <= 1'b1;
              resp_rdata_reg <= '0;
              if (~&decode_err_cnt_reg) decode_err_cnt_reg <= decode_err_cnt_reg + 1'b1;
            end
          end
        end
        ISSUE: begin
          // A completing target wins over a watchdog expiry in the same cycle.
          if (!tgt_hold[sel_reg]) begin
            state_reg      <= RESP;
            tgt_dv_reg     <= '0;
            resp_hold_reg  <= 1'b0;
            resp_error_reg <= tgt_error[sel_reg];
            resp_rdata_reg <= req_reg.write ? '0 : tgt_rdata[sel_reg*DW +: DW];
          end else if (WDOG_EN && (wait_cnt_reg == WAIT_LAST)) begin
            state_reg         <= RESP;
            tgt_dv_reg        <= '0;
            resp_hold_reg     <= 1'b0;
            resp_error_reg    <= 1'b1;
            resp_rdata_reg    <= '0;
            timeout_pulse_reg <= 1'b1;
            if (~&timeout_cnt_reg) timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        RESP: begin
          state_reg      <= IDLE;
          resp_hold_reg  <= 1'b1;
          resp_error_reg <= 1'b0;
          resp_rdata_reg <= '0;
          priv_req_reg   <= '0;
          soc_req_reg    <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.resp_hold  = resp_hold_reg;
  assign bus.resp_error = resp_error_reg;
  assign bus.resp_rdata = resp_rdata_reg;

  assign tgt_dv    = tgt_dv_reg;
  assign tgt_addr  = req_reg.addr[AW-1:0];
  assign tgt_write = req_reg.write;
  assign tgt_user  = req_reg.user[UW-1:0];
  assign tgt_id    = req_reg.id[IW-1:0];
  assign tgt_wdata = req_reg.wdata[DW-1:0];
  assign tgt_wstrb = req_reg.wstrb[DW/8-1:0];

  assign priv_req       = priv_req_reg;
  assign soc_req        = soc_req_reg;
  assign decode_err_cnt = decode_err_cnt_reg;
  assign timeout_cnt    = timeout_cnt_reg;
  assign timeout_pulse  = timeout_pulse_reg;

  // Padding bits of the wide request record and the raw hit vector are not needed here.
  assign unused_bits = ^{req_reg, dec_hit};

  // The upstream master must keep req_dv asserted until its response cycle.
  a_req_held: assert property (@(posedge clk) disable iff (rst)
                               (state_reg != IDLE) |-> bus.req_dv);

endmodule

// File: tb/tb_mci_cif_router.sv
// Randomised bench for mci_cif_router with a transaction-level reference model
// and a per-cycle compare process.
module tb_mci_cif_router;

  localparam int AW = 32, DW = 32, UW = 32, IW = 8;
  localparam int NT = 4, NP = 3, TO = 8, CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mci_cif_router_if #(.AW(AW), .DW(DW), .UW(UW), .IW(IW)) bus ();

  logic [NT-1:0]    tgt_dv, tgt_hold, tgt_error;
  logic [AW-1:0]    tgt_addr;
  logic             tgt_write;
  logic [UW-1:0]    tgt_user;
  logic [IW-1:0]    tgt_id;
  logic [DW-1:0]    tgt_wdata;
  logic [DW/8-1:0]  tgt_wstrb;
  logic [NT*DW-1:0] tgt_rdata;
  logic [NP*UW-1:0] strap;
  logic [NP-1:0]    priv_req;
  logic             soc_req;
  logic [CW-1:0]    dec_cnt, to_cnt;
  logic             to_pulse;

  logic [UW-1:0] strap_val [NP] = '{32'h1111_0000, 32'h2222_0000, 32'h3333_0000};
  assign strap = {strap_val[2], strap_val[1], strap_val[0]};

  // Windows as plain address ranges; target 2 overlaps target 0.
  logic [AW-1:0] win_lo [NT] = '{32'h0000_0000, 32'h0001_0000, 32'h0000_0000, 32'h0004_0000};
  logic [AW-1:0] win_hi [NT] = '{32'h0000_FFFF, 32'h0001_FFFF, 32'h0000_0FFF, 32'h0007_FFFF};

  mci_cif_router #(
    .AW(AW), .DW(DW), .UW(UW), .IW(IW), .NUM_TGT(NT),
    .TGT_BASE({32'h0004_0000, 32'h0000_0000, 32'h0001_0000, 32'h0000_0000}),
    .TGT_MASK({32'h0003_FFFF, 32'h0000_0FFF, 32'h0000_FFFF, 32'h0000_FFFF}),
    .NUM_PRIV(NP), .TIMEOUT_CYCLES(TO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .tgt_dv(tgt_dv), .tgt_addr(tgt_addr), .tgt_write(tgt_write), .tgt_user(tgt_user),
    .tgt_id(tgt_id), .tgt_wdata(tgt_wdata), .tgt_wstrb(tgt_wstrb),
    .tgt_hold(tgt_hold), .tgt_error(tgt_error), .tgt_rdata(tgt_rdata),
    .strap_priv_user(strap), .priv_req(priv_req), .soc_req(soc_req),
    .decode_err_cnt(dec_cnt), .timeout_cnt(to_cnt), .timeout_pulse(to_pulse)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model of the transaction in flight (cycle 1 = first cycle req_dv is shown).
  logic          txn_active = 1'b0;
  int            txn_cyc = 0;
  int            m_sel, m_h, m_resp_cyc, m_dv_len;
  logic          m_timeout, m_err;
  logic [DW-1:0] m_rdata;
  logic [NP-1:0] m_priv;
  logic [AW-1:0] m_addr;
  logic          m_write;
  logic [UW-1:0] m_user;
  logic [IW-1:0] m_id;
  logic [DW-1:0] m_wdata;
  logic [3:0]    m_wstrb;
  int            m_dec_cnt = 0, m_to_cnt = 0;

  // Driver-side observations used by the literal checks.
  int            obs_resp_cyc, obs_dv_cycles, obs_pulses;
  logic          obs_err, obs_soc, done;
  logic [DW-1:0] obs_rdata;
  logic [NT-1:0] obs_dv_or;
  logic [NP-1:0] obs_priv;

  logic          c_resp, c_dv;
  logic [NT-1:0] e_dv;
  logic [NP-1:0] e_priv;
  logic          e_soc;

  always @(negedge clk) begin
    if (!rst) begin
      if (txn_active) begin
        c_resp = (txn_cyc == m_resp_cyc);
        c_dv   = (m_sel >= 0) && (txn_cyc >= 2) && (txn_cyc < 2 + m_dv_len);
        e_dv   = c_dv ? (NT'(1) << m_sel) : '0;
        e_priv = (txn_cyc >= 2 && txn_cyc <= m_resp_cyc) ? m_priv : '0;
        e_soc  = (txn_cyc >= 2 && txn_cyc <= m_resp_cyc) && (m_priv == '0);
        if (c_resp) begin
          if (m_sel < 0)  m_dec_cnt = (m_dec_cnt < CNT_MAX) ? m_dec_cnt + 1 : CNT_MAX;
          if (m_timeout)  m_to_cnt  = (m_to_cnt  < CNT_MAX) ? m_to_cnt  + 1 : CNT_MAX;
        end
        check("resp_hold", bus.resp_hold, !c_resp);
        check("tgt_dv", tgt_dv, e_dv);
        check("timeout_pulse", to_pulse, c_resp && m_timeout);
        check("priv_req", priv_req, e_priv);
        check("soc_req", soc_req, e_soc);
        if (c_dv) begin
          check("tgt_addr", tgt_addr, m_addr);
          check("tgt_write", tgt_write, m_write);
          check("tgt_user", tgt_user, m_user);
          check("tgt_id", tgt_id, m_id);
          check("tgt_wdata", tgt_wdata, m_wdata);
          check("tgt_wstrb", tgt_wstrb, m_wstrb);
        end
        if (c_resp) begin
          check("resp_error", bus.resp_error, m_err);
          check("resp_rdata", bus.resp_rdata, m_rdata);
        end
      end else begin
        check("idle_resp_hold", bus.resp_hold, 1'b1);
        check("idle_tgt_dv", tgt_dv, '0);
        check("idle_pulse", to_pulse, 1'b0);
        check("idle_priv_req", priv_req, '0);
        check("idle_soc_req", soc_req, 1'b0);
      end
      check("decode_err_cnt", dec_cnt, m_dec_cnt);
      check("timeout_cnt", to_cnt, m_to_cnt);
    end
  end

  task automatic drive_hold();
    tgt_hold = NT'($urandom);
    if (m_sel >= 0) tgt_hold[m_sel] = (txn_cyc - 2 < m_h);
  endtask

  task automatic start_txn(input logic [AW-1:0] addr, input logic wr, input logic [UW-1:0] user,
                           input int h, input logic [NT*DW-1:0] rd_all, input logic [NT-1:0] err_all);
    int sel;
    sel = -1;
    for (int i = NT - 1; i >= 0; i--) begin
      if (addr >= win_lo[i] && addr <= win_hi[i]) sel = i;
    end
    tgt_rdata  = rd_all;
    tgt_error  = err_all;
    m_sel      = sel;
    m_h        = h;
    m_timeout  = (sel >= 0) && (h >= TO);
    m_resp_cyc = (sel < 0) ? 2 : ((h < TO) ? 3 + h : 2 + TO);
    m_dv_len   = (h < TO) ? h + 1 : TO;
    if (sel < 0 || m_timeout) m_err = 1'b1;
    else                      m_err = err_all[sel];
    if (sel < 0 || m_timeout || wr) m_rdata = '0;
    else                            m_rdata = rd_all[sel*DW +: DW];
    for (int j = 0; j < NP; j++) m_priv[j] = (user == strap_val[j]);
    m_addr  = addr;
    m_write = wr;
    m_user  = user;
    m_id    = IW'($urandom);
    m_wdata = $urandom;
    m_wstrb = 4'($urandom);
    bus.req_addr  = addr;
    bus.req_write = wr;
    bus.req_user  = user;
    bus.req_id    = m_id;
    bus.req_wdata = m_wdata;
    bus.req_wstrb = m_wstrb;
    bus.req_dv    = 1'b1;
    txn_cyc       = 1;
    txn_active    = 1'b1;
    obs_resp_cyc  = -1;
    obs_dv_cycles = 0;
    obs_pulses    = 0;
    obs_dv_or     = '0;
    done          = 1'b0;
    drive_hold();
  endtask

  // Runs cycles until the DUT completes (resp_hold low) or a budget of max_cyc expires.
  task automatic advance(input int max_cyc);
    for (int k = 0; k < max_cyc && !done; k++) begin
      @(negedge clk);
      if (tgt_dv != '0) obs_dv_cycles++;
      obs_dv_or = obs_dv_or | tgt_dv;
      if (to_pulse) obs_pulses++;
      if (!bus.resp_hold) begin
        done         = 1'b1;
        obs_resp_cyc = txn_cyc;
        obs_err      = bus.resp_error;
        obs_rdata    = bus.resp_rdata;
        obs_priv     = priv_req;
        obs_soc      = soc_req;
      end
      @(posedge clk);
      #1;
      if (!done) begin
        txn_cyc++;
        drive_hold();
      end
    end
  endtask

  task automatic finish_txn();
    advance(40);
    check("txn_completion", done, 1'b1);
    bus.req_dv = 1'b0;
    txn_active = 1'b0;
    tgt_hold   = NT'($urandom);
  endtask

  task automatic run_txn(input logic [AW-1:0] addr, input logic wr, input logic [UW-1:0] user,
                         input int h, input logic [NT*DW-1:0] rd_all, input logic [NT-1:0] err_all);
    start_txn(addr, wr, user, h, rd_all, err_all);
    finish_txn();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [NT*DW-1:0] rand_rd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit expired");
  end

  initial begin
    logic [AW-1:0] a;
    logic [UW-1:0] u;
    int            kind;

    bus.req_dv = 1'b0; bus.req_addr = '0; bus.req_write = 1'b0; bus.req_user = '0;
    bus.req_id = '0;   bus.req_wdata = '0; bus.req_wstrb = '0;
    tgt_hold = '0; tgt_error = '0; tgt_rdata = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_resp_hold", bus.resp_hold, 1'b1);
    check("rst_resp_error", bus.resp_error, 1'b0);
    check("rst_resp_rdata", bus.resp_rdata, 32'h0);
    check("rst_tgt_dv", tgt_dv, 4'h0);
    check("rst_tgt_addr", tgt_addr, 32'h0);
    check("rst_priv_req", priv_req, 3'b000);
    check("rst_soc_req", soc_req, 1'b0);
    check("rst_counters", {dec_cnt, to_cnt}, 8'h00);
    check("rst_pulse", to_pulse, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Zero-wait read from target 1.
    run_txn(32'h0001_0004, 1'b0, 32'h0000_1234, 0, {32'h0, 32'h0, 32'hCAFE_F00D, 32'h0}, 4'b0000);
    check("read_latency", obs_resp_cyc, 3);
    check("read_rdata", obs_rdata, 32'hCAFE_F00D);
    check("read_error", obs_err, 1'b0);
    check("read_tgt_dv", obs_dv_or, 4'b0010);
    check("read_dv_cycles", obs_dv_cycles, 1);
    idle(1);

    // Unmapped write.
    run_txn(32'h2000_0000, 1'b1, 32'h0000_1234, 0, rand_rd(), 4'b0000);
    check("unmapped_latency", obs_resp_cyc, 2);
    check("unmapped_error", obs_err, 1'b1);
    check("unmapped_rdata", obs_rdata, 32'h0);
    check("unmapped_tgt_dv", obs_dv_or, 4'b0000);
    check("unmapped_cnt", dec_cnt, 4'h1);

    // Target 1 holds forever: watchdog expiry.
    run_txn(32'h0001_0008, 1'b0, 32'h0000_1234, 1000, rand_rd(), 4'b0000);
    check("timeout_dv_cycles", obs_dv_cycles, 8);
    check("timeout_pulses", obs_pulses, 1);
    check("timeout_error", obs_err, 1'b1);
    check("timeout_latency", obs_resp_cyc, 10);
    check("timeout_cnt_lit", to_cnt, 4'h1);

    // Privilege classification.
    run_txn(32'h0000_0010, 1'b0, 32'h2222_0000, 1, rand_rd(), 4'b0000);
    check("priv_strap1", obs_priv, 3'b010);
    check("soc_strap1", obs_soc, 1'b0);
    run_txn(32'h0000_0010, 1'b0, 32'h2222_0001, 1, rand_rd(), 4'b0000);
    check("priv_none", obs_priv, 3'b000);
    check("soc_none", obs_soc, 1'b1);

    // Overlapping windows 0 and 2 both contain 0x100.
    run_txn(32'h0000_0100, 1'b0, 32'h0, 0, rand_rd(), 4'b0000);
    check("overlap_tgt_dv", obs_dv_or, 4'b0001);

    for (int t = 0; t < 150; t++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0:       a = AW'($urandom_range(0, 32'hFFFF));
        1:       a = 32'h0001_0000 + AW'($urandom_range(0, 32'hFFFF));
        2:       a = 32'h0004_0000 + AW'($urandom_range(0, 32'h3FFFF));
        3:       a = $urandom;
        default: a = AW'($urandom_range(0, 32'hFFF));
      endcase
      u = ($urandom_range(0, 1) == 1) ? strap_val[$urandom_range(0, NP - 1)] : $urandom;
      run_txn(a, 1'($urandom), u, $urandom_range(0, 10), rand_rd(), NT'($urandom));
      idle($urandom_range(0, 2));
    end

    // Reset while target 1 is holding in the issue phase.
    start_txn(32'h0001_0010, 1'b0, 32'h0, 1000, rand_rd(), 4'b0000);
    advance(3);
    rst        = 1'b1;
    bus.req_dv = 1'b0;
    txn_active = 1'b0;
    m_dec_cnt  = 0;
    m_to_cnt   = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_tgt_dv", tgt_dv, 4'h0);
    check("midrst_resp_hold", bus.resp_hold, 1'b1);
    check("midrst_counters", {dec_cnt, to_cnt}, 8'h00);
    @(posedge clk);
    #1;
    run_txn(32'h0001_0004, 1'b0, 32'h0, 0, rand_rd(), 4'b0000);
    check("postrst_latency", obs_resp_cyc, 3);

    // Drive enough unmapped requests to saturate the 4-bit decode error counter.
    for (int t = 0; t < 20; t++) begin
      run_txn(32'h2000_0000 + AW'(t * 4), 1'b0, 32'h0, 0, rand_rd(), 4'b0000);
    end
    check("decode_cnt_saturated", dec_cnt, 4'hF);

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
